// File: rtl/clk_rst_sequencer.sv
// Reset conditioner: synchronizes seven raw reset requests, stretches short bursts
// to a minimum width, measures burst length and releases ports one at a time.

module clk_rst_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic c_clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] sync_pipe;

    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) sync_pipe <= '0;
        else       sync_pipe <= {sync_pipe[STAGES-2:0], d};
    end

    assign q = sync_pipe[STAGES-1];
endmodule

module clk_rst_sequencer #(
    parameter int MIN_RST_CYC = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic       c_clk,
    input  logic       reset,
    input  logic [1:7] rst_in,
    output logic [1:7] port_rst,
    output logic [7:0] rst_len,
    output logic       len_valid,
    output logic       short_err,
    output logic       sys_ready
);
    typedef enum logic [1:0] {ST_IDLE, ST_ASSERT, ST_STRETCH, ST_RELEASE} state_t;

    localparam logic [7:0] MIN_CNT = 8'(MIN_RST_CYC);

    state_t     state;
    logic [1:7] sync;
    logic [1:7] mask;
    logic [1:7] rel_mask;
    logic [7:0] cnt;
    logic [7:0] cnt_inc;
    logic       any_rst;

    for (genvar i = 1; i <= 7; i++) begin : g_sync
        clk_rst_sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
            .c_clk (c_clk),
            .reset (reset),
            .d     (rst_in[i]),
            .q     (sync[i])
        );
    end

    assign any_rst  = |sync;
    assign cnt_inc  = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
    assign port_rst = mask;

    // Scan from the top so the lowest-index set bit is the one that ends up cleared.
    always_comb begin
        rel_mask = mask;
        for (int i = 7; i >= 1; i--) begin
            if (mask[i]) begin
                rel_mask    = mask;
                rel_mask[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            state     <= ST_STRETCH;
            mask      <= '1;
            cnt       <= '0;
            rst_len   <= '0;
            len_valid <= 1'b0;
            short_err <= 1'b0;
            sys_ready <= 1'b0;
        end else begin
            len_valid <= 1'b0;
            sys_ready <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (any_rst) begin
                        state <= ST_ASSERT;
                        mask  <= mask | sync;
                        cnt   <= 8'd1;
                    end else begin
                        mask      <= '0;
                        sys_ready <= 1'b1;
                    end
                end
                ST_ASSERT: begin
                    if (any_rst) begin
                        mask <= mask | sync;
                        cnt  <= cnt_inc;
                    end else begin
                        rst_len   <= cnt;
                        len_valid <= 1'b1;
                        if (cnt < MIN_CNT) begin
                            short_err <= 1'b1;
                            state     <= ST_STRETCH;
                        end else begin
                            state <= ST_RELEASE;
                        end
                    end
                end
                ST_STRETCH: begin
                    cnt <= cnt_inc;
                    if (any_rst) begin
                        state <= ST_ASSERT;
                        mask  <= mask | sync;
                    end else if (cnt_inc >= MIN_CNT) begin
                        state <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    // A new request restarts the burst; already-released ports stay low unless requested.
                    if (any_rst) begin
                        state <= ST_ASSERT;
                        mask  <= mask | sync;
                        cnt   <= 8'd1;
                    end else begin
                        mask <= rel_mask;
                        if (rel_mask == '0) begin
                            state     <= ST_IDLE;
                            sys_ready <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_clk_rst_sequencer.sv
// Self-checking bench for clk_rst_sequencer: directed scenarios plus randomized
// requests compared against a cycle-level behavioural model.
`timescale 1ns/1ps

module tb_clk_rst_sequencer;
    localparam int MIN_RST_CYC = 4;
    localparam int SYNC_STAGES = 2;

    logic       c_clk = 1'b0;
    logic       reset;
    logic [1:7] rst_in;
    logic [1:7] port_rst;
    logic [7:0] rst_len;
    logic       len_valid;
    logic       short_err;
    logic       sys_ready;

    int total = 0;
    int bad   = 0;

    clk_rst_sequencer #(.MIN_RST_CYC(MIN_RST_CYC), .SYNC_STAGES(SYNC_STAGES)) dut (
        .c_clk     (c_clk),
        .reset     (reset),
        .rst_in    (rst_in),
        .port_rst  (port_rst),
        .rst_len   (rst_len),
        .len_valid (len_valid),
        .short_err (short_err),
        .sys_ready (sys_ready)
    );

    always #100 c_clk = ~c_clk;

    initial begin
        #(200.0 * 50000);
        $display("FAIL watchdog expired got=running exp=finished");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge c_clk);
        #1;
    endtask

    // ---------------- behavioural model (ports held as bits 1..7 of an int) ----------------
    localparam int M_QUIET = 0, M_ACTIVE = 1, M_EXTEND = 2, M_DRAIN = 3;
    int m_mode, m_mask, m_cnt, m_len, m_lv, m_err;
    int m_hist[$];

    function automatic int to_bits(input logic [1:7] v);
        int r = 0;
        for (int i = 1; i <= 7; i++) if (v[i]) r |= (1 << i);
        return r;
    endfunction

    task automatic model_reset();
        m_mode = M_EXTEND;
        m_mask = 'hFE;
        m_cnt  = 0;
        m_len  = 0;
        m_lv   = 0;
        m_err  = 0;
        m_hist.delete();
    endtask

    task automatic model_edge(input logic [1:7] din);
        int seen = 0;
        m_hist.push_back(to_bits(din));
        if (m_hist.size() > SYNC_STAGES) begin
            seen = m_hist[0];
            void'(m_hist.pop_front());
        end
        m_lv = 0;
        case (m_mode)
            M_QUIET: begin
                m_mask = seen;
                if (seen != 0) begin m_cnt = 1; m_mode = M_ACTIVE; end
            end
            M_ACTIVE: begin
                if (seen != 0) begin
                    m_mask |= seen;
                    m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
                end else begin
                    m_len = m_cnt;
                    m_lv  = 1;
                    if (m_cnt < MIN_RST_CYC) begin m_err = 1; m_mode = M_EXTEND; end
                    else m_mode = M_DRAIN;
                end
            end
            M_EXTEND: begin
                m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
                if (seen != 0) begin m_mask |= seen; m_mode = M_ACTIVE; end
                else if (m_cnt >= MIN_RST_CYC) m_mode = M_DRAIN;
            end
            default: begin
                if (seen != 0) begin
                    m_mask |= seen;
                    m_cnt  = 1;
                    m_mode = M_ACTIVE;
                end else begin
                    for (int i = 1; i <= 7; i++) begin
                        if ((m_mask & (1 << i)) != 0) begin m_mask &= ~(1 << i); break; end
                    end
                    if (m_mask == 0) m_mode = M_QUIET;
                end
            end
        endcase
    endtask

    // ---------------- directed scenarios ----------------
    task automatic test_reset();
        logic [1:7] full = 7'h7F;
        logic [1:7] exp_p;
        reset  = 1'b1;
        rst_in = '0;
        repeat (3) tick();
        total++;
        if (port_rst !== 7'h7F || {rst_len, len_valid, short_err, sys_ready} !== 11'h0) begin
            bad++;
            $display("FAIL reset_hold got=%h/%h/%b%b%b exp=7f/00/000", port_rst, rst_len, len_valid, short_err, sys_ready);
        end
        reset = 1'b0;
        for (int j = 1; j <= 11; j++) begin
            tick();
            exp_p = (j <= MIN_RST_CYC) ? full : full >> (j - MIN_RST_CYC);
            total++;
            if (port_rst !== exp_p) begin
                bad++; $display("FAIL powerup_port_rst edge=%0d got=%h exp=%h", j, port_rst, exp_p);
            end
            total++;
            if (sys_ready !== (j == 11)) begin
                bad++; $display("FAIL powerup_sys_ready edge=%0d got=%b exp=%b", j, sys_ready, (j == 11));
            end
            total++;
            if (len_valid !== 1'b0 || short_err !== 1'b0) begin
                bad++; $display("FAIL powerup_flags edge=%0d got=%b%b exp=00", j, len_valid, short_err);
            end
        end
    endtask

    task automatic test_nominal();
        logic [1:7] exp_p;
        rst_in = 7'b1000000;
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (k == 4) rst_in = '0;
            exp_p = (k >= 3 && k <= 7) ? 7'b1000000 : 7'b0000000;
            total++;
            if (port_rst !== exp_p || len_valid !== (k == 7) || sys_ready !== !(k >= 3 && k <= 7)) begin
                bad++;
                $display("FAIL nominal edge=%0d got=%h/%b/%b exp=%h/%b/%b", k, port_rst, len_valid, sys_ready,
                         exp_p, (k == 7), !(k >= 3 && k <= 7));
            end
        end
        total++;
        if (rst_len !== 8'd4 || short_err !== 1'b0) begin
            bad++; $display("FAIL nominal_len got=%0d/%b exp=4/0", rst_len, short_err);
        end
    endtask

    task automatic test_short();
        logic [1:7] exp_p;
        rst_in = 7'b0010000;
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (k == 1) rst_in = '0;
            exp_p = (k >= 3 && k <= 7) ? 7'b0010000 : 7'b0000000;
            total++;
            if (port_rst !== exp_p || len_valid !== (k == 4) || short_err !== (k >= 4)) begin
                bad++;
                $display("FAIL short edge=%0d got=%h/%b/%b exp=%h/%b/%b", k, port_rst, len_valid, short_err,
                         exp_p, (k == 4), (k >= 4));
            end
        end
        total++;
        if (rst_len !== 8'd1 || sys_ready !== 1'b1) begin
            bad++; $display("FAIL short_len got=%0d/%b exp=1/1", rst_len, sys_ready);
        end
    endtask

    task automatic test_overlap();
        logic [1:7] exp_p;
        int pulses = 0;
        rst_in = 7'b0100000;
        for (int k = 1; k <= 14; k++) begin
            tick();
            if (k == 2) rst_in[6] = 1'b1;
            if (k == 5) rst_in[2] = 1'b0;
            if (k == 8) rst_in[6] = 1'b0;
            if (len_valid) pulses++;
            if (k <= 2 || k >= 13) exp_p = 7'b0000000;
            else if (k <= 4)       exp_p = 7'b0100000;
            else if (k <= 11)      exp_p = 7'b0100010;
            else                   exp_p = 7'b0000010;
            total++;
            if (port_rst !== exp_p || sys_ready !== (k <= 2 || k >= 13)) begin
                bad++;
                $display("FAIL overlap edge=%0d got=%h/%b exp=%h/%b", k, port_rst, sys_ready, exp_p, (k <= 2 || k >= 13));
            end
        end
        total++;
        if (pulses != 1 || rst_len !== 8'd8) begin
            bad++; $display("FAIL overlap_len got=%0d pulses len=%0d exp=1 pulses len=8", pulses, rst_len);
        end
    endtask

    task automatic test_reentry();
        logic [1:7] exp_p;
        rst_in = 7'b1000100;
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (k == 4) rst_in = '0;
            if (k == 6) rst_in[5] = 1'b1;
            if (k == 7) rst_in[5] = 1'b0;
            if (k <= 2 || k >= 14) exp_p = 7'b0000000;
            else if (k <= 7)       exp_p = 7'b1000100;
            else                   exp_p = 7'b0000100;
            total++;
            if (port_rst !== exp_p || sys_ready !== (k <= 2 || k >= 14) || len_valid !== (k == 7 || k == 10)) begin
                bad++;
                $display("FAIL reentry edge=%0d got=%h/%b/%b exp=%h/%b/%b", k, port_rst, sys_ready, len_valid,
                         exp_p, (k <= 2 || k >= 14), (k == 7 || k == 10));
            end
            if (k == 7 || k == 10) begin
                total++;
                if (rst_len !== ((k == 7) ? 8'd4 : 8'd1)) begin
                    bad++; $display("FAIL reentry_len edge=%0d got=%0d exp=%0d", k, rst_len, (k == 7) ? 4 : 1);
                end
            end
        end
    endtask

    task automatic test_saturation();
        int pulses = 0;
        rst_in = 7'b0000001;
        for (int k = 1; k <= 303; k++) begin
            tick();
            if (k == 300) rst_in = '0;
            if (len_valid) pulses++;
        end
        total++;
        if (pulses != 1 || len_valid !== 1'b1 || rst_len !== 8'd255 || port_rst !== 7'b0000001) begin
            bad++;
            $display("FAIL saturate got=%0d pulses lv=%b len=%0d port=%h exp=1 pulses lv=1 len=255 port=01",
                     pulses, len_valid, rst_len, port_rst);
        end
        tick();
        total++;
        if (port_rst !== 7'h00 || sys_ready !== 1'b1) begin
            bad++; $display("FAIL saturate_release got=%h/%b exp=00/1", port_rst, sys_ready);
        end
        rst_in = 7'b0000001;
        repeat (10) tick();
        total++;
        if (port_rst !== 7'b0000001 || sys_ready !== 1'b0 || short_err !== 1'b1) begin
            bad++; $display("FAIL midburst_pre got=%h/%b/%b exp=01/0/1", port_rst, sys_ready, short_err);
        end
        #50 reset = 1'b1;
        #1;
        total++;
        if (port_rst !== 7'h7F || {rst_len, len_valid, short_err, sys_ready} !== 11'h0) begin
            bad++;
            $display("FAIL async_reset got=%h/%h/%b%b%b exp=7f/00/000", port_rst, rst_len, len_valid, short_err, sys_ready);
        end
        rst_in = '0;
        tick();
        tick();
        reset = 1'b0;
        repeat (11) tick();
        total++;
        if (port_rst !== 7'h00 || sys_ready !== 1'b1) begin
            bad++; $display("FAIL async_reset_recover got=%h/%b exp=00/1", port_rst, sys_ready);
        end
    endtask

    task automatic test_random();
        logic [1:7] drv = '0;
        reset  = 1'b1;
        rst_in = '0;
        model_reset();
        tick();
        tick();
        reset = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            model_edge(drv);
            total++;
            if (to_bits(port_rst) != m_mask || rst_len !== 8'(m_len) || len_valid !== m_lv[0] ||
                short_err !== m_err[0] || sys_ready !== (m_mode == M_QUIET && m_mask == 0)) begin
                bad++;
                $display("FAIL random cyc=%0d got=%h/%0d/%b%b%b exp=%h/%0d/%0d%0d%0d", c, port_rst, rst_len,
                         len_valid, short_err, sys_ready, m_mask >> 1, m_len, m_lv, m_err,
                         (m_mode == M_QUIET && m_mask == 0));
            end
            if ($urandom_range(0, 599) == 0) begin
                reset = 1'b1;
                drv   = '0;
                rst_in = drv;
                model_reset();
                #1;
                total++;
                if (to_bits(port_rst) != m_mask || sys_ready !== 1'b0 || short_err !== 1'b0) begin
                    bad++; $display("FAIL random_reset cyc=%0d got=%h/%b/%b exp=7f/0/0", c, port_rst, sys_ready, short_err);
                end
                tick();
                reset = 1'b0;
            end else begin
                for (int i = 1; i <= 7; i++) begin
                    if (drv[i]) begin
                        if ($urandom_range(0, 3) == 0) drv[i] = 1'b0;
                    end else if ($urandom_range(0, 24) == 0) begin
                        drv[i] = 1'b1;
                    end
                end
                rst_in = drv;
            end
        end
    endtask

    initial begin
        reset  = 1'b1;
        rst_in = '0;
        test_reset();
        test_nominal();
        test_short();
        test_overlap();
        test_reentry();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
